inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue.sv | 175 +++++++++++++++++
 tb/tb_inst_queue.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Two-wide in / two-wide out instruction queue: circular buffer with
// first-word-fall-through read lanes, occupancy counter and status flags.
module inst_queue #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4,
  parameter int NF_SLACK  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [1:0]           in_cnt,
  input  logic [DATA_W-1:0]    in_data0,
  input  logic [DATA_W-1:0]    in_data1,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    out_data0,
  output logic [DATA_W-1:0]    out_data1,
  output logic                 out_vld0,
  output logic                 out_vld1,
  input  logic [1:0]           pop_cnt,
  output logic [LOG_DEPTH:0]   count,
  output logic                 empty,
  output logic                 nearly_full
);

  localparam logic [LOG_DEPTH:0]   ZERO_CNT = {(LOG_DEPTH+1){1'b0}};
  localparam logic [LOG_DEPTH:0]   TWO_CNT  = {{(LOG_DEPTH-1){1'b0}}, 2'd2};
  localparam logic [LOG_DEPTH-1:0] ZERO_PTR = {LOG_DEPTH{1'b0}};
  localparam logic [LOG_DEPTH-1:0] ONE_PTR  = {{(LOG_DEPTH-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]    mem [DEPTH];
  logic [LOG_DEPTH-1:0] rptr_r;
  logic [LOG_DEPTH-1:0] wptr_r;
  logic [LOG_DEPTH-1:0] rptr_p1_s;
  logic [LOG_DEPTH-1:0] wptr_p1_s;
  logic [LOG_DEPTH:0]   count_r;
  logic [LOG_DEPTH:0]   count_next_s;
  logic [1:0]           in_cnt_s;
  logic [1:0]           pop_req_s;
  logic [1:0]           push_n_s;
  logic [1:0]           pop_n_s;
  logic                 in_ready_r;
  logic                 empty_r;
  logic                 nf_r;
  logic                 vld0_r;
  logic                 vld1_r;

  function automatic logic ready_of(input logic [LOG_DEPTH:0] c);
    return int'(c) <= (DEPTH - 32'sd2);
  endfunction

  function automatic logic nf_of(input logic [LOG_DEPTH:0] c);
    return (DEPTH - int'(c)) <= NF_SLACK;
  endfunction

  assign rptr_p1_s = rptr_r + ONE_PTR;
  assign wptr_p1_s = wptr_r + ONE_PTR;

  // Clip request widths to the two physical lanes.
  always_comb begin
    case (in_cnt)
      2'd3:    in_cnt_s = 2'd2;
      default: in_cnt_s = in_cnt;
    endcase
    case (pop_cnt)
      2'd3:    pop_req_s = 2'd2;
      default: pop_req_s = pop_cnt;
    endcase
  end

  // Accepted push/pop amounts; pops never exceed occupancy.
  always_comb begin
    if (in_valid && in_ready_r && !flush) begin
      push_n_s = in_cnt_s;
    end else begin
      push_n_s = 2'd0;
    end
    if (flush) begin
      pop_n_s = 2'd0;
    end else if ({{(LOG_DEPTH-1){1'b0}}, pop_req_s} > count_r) begin
      pop_n_s = count_r[1:0];
    end else begin
      pop_n_s = pop_req_s;
    end
  end

  // Next occupancy; flush empties the queue regardless of traffic.
  always_comb begin
    if (flush) begin
      count_next_s = ZERO_CNT;
    end else begin
      count_next_s = count_r + {{(LOG_DEPTH-1){1'b0}}, push_n_s}
                             - {{(LOG_DEPTH-1){1'b0}}, pop_n_s};
    end
  end

  // Pointers, occupancy and flags registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_r     <= ZERO_PTR;
      wptr_r     <= ZERO_PTR;
      count_r    <= ZERO_CNT;
      in_ready_r <= 1'b1;
      empty_r    <= 1'b1;
      nf_r       <= nf_of(ZERO_CNT);
      vld0_r     <= 1'b0;
      vld1_r     <= 1'b0;
    end else begin
      if (flush) begin
        rptr_r <= ZERO_PTR;
        wptr_r <= ZERO_PTR;
      end else begin
        rptr_r <= rptr_r + {{(LOG_DEPTH-2){1'b0}}, pop_n_s};
        wptr_r <= wptr_r + {{(LOG_DEPTH-2){1'b0}}, push_n_s};
      end
      count_r    <= count_next_s;
      in_ready_r <= ready_of(count_next_s);
      empty_r    <= (count_next_s == ZERO_CNT);
      nf_r       <= nf_of(count_next_s);
      vld0_r     <= (count_next_s != ZERO_CNT);
      vld1_r     <= (count_next_s >= TWO_CNT);
    end
  end

  // Storage has no reset; nothing reads an entry before it is written.
  always_ff @(posedge clk) begin
    if (!rst && push_n_s != 2'd0) begin
      mem[wptr_r] <= in_data0;
    end
    if (!rst && push_n_s == 2'd2) begin
      mem[wptr_p1_s] <= in_data1;
    end
  end

  assign out_data0   = vld0_r ? mem[rptr_r]    : {DATA_W{1'b0}};
  assign out_data1   = vld1_r ? mem[rptr_p1_s] : {DATA_W{1'b0}};
  assign out_vld0    = vld0_r;
  assign out_vld1    = vld1_r;
  assign in_ready    = in_ready_r;
  assign count       = count_r;
  assign empty       = empty_r;
  assign nearly_full = nf_r;

  inst_queue_chk #(
    .DEPTH     (DEPTH),
    .LOG_DEPTH (LOG_DEPTH)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .count    (count_r),
    .in_ready (in_ready_r)
  );

endmodule

module inst_queue_chk #(
  parameter int DEPTH     = 16,
  parameter int LOG_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic [LOG_DEPTH:0]   count,
  input logic                 in_ready
);

  localparam logic [LOG_DEPTH:0] FULL_CNT = DEPTH[LOG_DEPTH:0];

  a_full_not_ready: assert property (@(posedge clk) disable iff (rst)
    (count == FULL_CNT) |-> !in_ready);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    count <= FULL_CNT);

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: vector table plus hand-written sequences
// for fill, wrap, flush and mid-stream reset.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [1:0]  in_cnt;
  logic [63:0] in_data0;
  logic [63:0] in_data1;
  logic        in_ready;
  logic [63:0] out_data0;
  logic [63:0] out_data1;
  logic        out_vld0;
  logic        out_vld1;
  logic [1:0]  pop_cnt;
  logic [4:0]  count;
  logic        empty;
  logic        nearly_full;

  always #5 clk = ~clk;

  inst_queue dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_cnt      (in_cnt),
    .in_data0    (in_data0),
    .in_data1    (in_data1),
    .in_ready    (in_ready),
    .out_data0   (out_data0),
    .out_data1   (out_data1),
    .out_vld0    (out_vld0),
    .out_vld1    (out_vld1),
    .pop_cnt     (pop_cnt),
    .count       (count),
    .empty       (empty),
    .nearly_full (nearly_full)
  );

  typedef struct {
    logic        r;
    logic        f;
    logic        v;
    logic [1:0]  ic;
    logic [63:0] d0;
    logic [63:0] d1;
    logic [1:0]  pc;
    logic [4:0]  c;
    logic        e;
    logic        rdy;
    logic        nf;
    logic        v0;
    logic        v1;
    logic [63:0] o0;
    logic [63:0] o1;
  } vec_t;

  vec_t tbl [10];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then return to idle 1 time unit after the edge.
  task automatic step(input logic r, input logic f, input logic v, input logic [1:0] ic,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] pc);
    rst = r; flush = f; in_valid = v; in_cnt = ic;
    in_data0 = d0; in_data1 = d1; pop_cnt = pc;
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_cnt = 2'd0; pop_cnt = 2'd0;
  endtask

  // flags packed as {empty, in_ready, nearly_full, out_vld0, out_vld1}
  task automatic chk_st(input string name, input logic [4:0] c, input logic e, input logic rdy,
                        input logic nf, input logic v0, input logic v1,
                        input logic [63:0] o0, input logic [63:0] o1);
    chk({name, ".count"}, 64'(count), 64'(c));
    chk({name, ".flags"}, {59'd0, empty, in_ready, nearly_full, out_vld0, out_vld1},
        {59'd0, e, rdy, nf, v0, v1});
    chk({name, ".out0"}, out_data0, o0);
    chk({name, ".out1"}, out_data1, o1);
  endtask

  initial begin
    logic [4:0] ec;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_cnt = 2'd0; pop_cnt = 2'd0;
    in_data0 = 64'd0; in_data1 = 64'd0;

    //            r     f     v     ic    d0        d1        pc    c     e     rdy   nf    v0    v1    o0        o1
    tbl[0] = '{1'b0, 1'b0, 1'b1, 2'd2, 64'h100, 64'h101, 2'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h100, 64'h101};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 2'd1, 64'h102, 64'hdead, 2'd1, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h101, 64'h102};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,   64'h0,   2'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 2'd1, 64'h103, 64'hdead, 2'd0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h103, 64'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,   64'h0,   2'd2, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 2'd3, 64'h104, 64'h105, 2'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h104, 64'h105};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 2'd2, 64'h106, 64'h107, 2'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h104, 64'h105};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 2'd2, 64'h108, 64'h109, 2'd1, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0,   64'h0};
    tbl[8] = '{1'b0, 1'b0, 1'b1, 2'd2, 64'h10a, 64'h10b, 2'd0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h10a, 64'h10b};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 2'd0, 64'h0,   64'h0,   2'd1, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h10b, 64'h0};

    step(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
    chk_st("reset", 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].ic, tbl[i].d0, tbl[i].d1, tbl[i].pc);
      chk_st($sformatf("vec%0d", i), tbl[i].c, tbl[i].e, tbl[i].rdy, tbl[i].nf,
             tbl[i].v0, tbl[i].v1, tbl[i].o0, tbl[i].o1);
    end

    // Fill to 14 two at a time, then to full; pushes while full are dropped.
    step(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'd2, 64'h200 + 64'(2*i), 64'h201 + 64'(2*i), 2'd0);
      ec = 5'(2*(i+1));
      chk_st($sformatf("fill%0d", i), ec, 1'b0, 1'b1, (16 - 2*(i+1)) <= 4, 1'b1, 1'b1,
             64'h200, 64'h201);
    end
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'h20e, 64'h20f, 2'd0);
    chk_st("full", 5'd16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h200, 64'h201);
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'h2f0, 64'h2f1, 2'd0);
    chk_st("full_drop", 5'd16, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h200, 64'h201);
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'h2f2, 64'h2f3, 2'd1);
    chk_st("pop_15", 5'd15, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h201, 64'h202);
    step(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd1);
    chk_st("pop_14", 5'd14, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h202, 64'h203);

    // Simultaneous push 2 / pop 1 at occupancy 5.
    step(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'h500, 64'h501, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'h502, 64'h503, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 64'h504, 64'h0, 2'd0);
    chk_st("pp_5", 5'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h500, 64'h501);
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'h505, 64'h506, 2'd1);
    chk_st("pp_6", 5'd6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h501, 64'h502);

    // Walk both pointers to 15, then a two-entry push straddles 15 -> 0.
    step(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'd1, 64'h300 + 64'(i), 64'h0, 2'd0);
      step(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd1);
    end
    chk_st("wrap_pre", 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'haaaa, 64'hbbbb, 2'd0);
    chk_st("wrap_push", 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'haaaa, 64'hbbbb);
    step(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd1);
    chk_st("wrap_pop1", 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hbbbb, 64'h0);
    step(1'b0, 1'b0, 1'b1, 2'd2, 64'hcccc, 64'hdddd, 2'd0);
    chk_st("wrap_push2", 5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'hbbbb, 64'hcccc);
    step(1'b0, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd2);
    chk_st("wrap_pop2", 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hdddd, 64'h0);

    // Flush beats a concurrent push 2 / pop 1 at occupancy 9.
    step(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'd2, 64'h400 + 64'(2*i), 64'h401 + 64'(2*i), 2'd0);
    end
    step(1'b0, 1'b0, 1'b1, 2'd1, 64'h408, 64'h0, 2'd0);
    chk_st("flush_pre", 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 64'h400, 64'h401);
    step(1'b0, 1'b1, 1'b1, 2'd2, 64'h4f0, 64'h4f1, 2'd1);
    chk_st("flush", 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    step(1'b0, 1'b0, 1'b1, 2'd1, 64'h4aa, 64'h0, 2'd0);
    chk_st("flush_post", 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 64'h4aa, 64'h0);

    // Reset with traffic at occupancy 12.
    step(1'b1, 1'b0, 1'b0, 2'd0, 64'd0, 64'd0, 2'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'd2, 64'h600 + 64'(2*i), 64'h601 + 64'(2*i), 2'd0);
    end
    chk_st("rst_pre", 5'd12, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 64'h600, 64'h601);
    step(1'b1, 1'b0, 1'b1, 2'd2, 64'h6f0, 64'h6f1, 2'd1);
    chk_st("rst_mid", 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
